// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: decimal operand entry, operator latching, ALU start/done handshake, display drive.
// Optional macro CALC_CHAIN_EN: an operator pressed while entering B evaluates first, then latches the new operator.
module calc_seq_ctrl #(
    parameter int W       = 16,
    parameter int MAX_VAL = 999
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                digit_vld,
    input  logic [3:0]          digit,
    input  logic                op_vld,
    input  logic [2:0]          op_code,
    input  logic                eq_vld,
    input  logic                neg_vld,
    output logic                alu_start,
    output logic [2:0]          alu_op,
    output logic signed [W-1:0] alu_a,
    output logic signed [W-1:0] alu_b,
    input  logic                alu_done,
    input  logic signed [W-1:0] alu_result,
    input  logic                alu_err,
    output logic signed [W-1:0] disp_val,
    output logic                disp_err,
    output logic                busy,
    output logic [2:0]          state_dbg
);

    // ALU handshake: alu_start is a one-cycle request; alu_op/alu_a/alu_b hold from
    // alu_start until alu_done, which arrives no earlier than the cycle after alu_start.
    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_OP_WAIT = 3'd1,
        S_ENTER_B = 3'd2,
        S_EXEC    = 3'd3,
        S_RESULT  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam logic signed [W-1:0] MAX_S = W'(MAX_VAL);
    localparam logic signed [W-1:0] MIN_S = -MAX_S;

    state_t              state;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                b_neg;
    logic [2:0]          op;
    logic [2:0]          pend_op;
    logic                chain_pend;

    logic                take_digit;
    logic                take_op;
    logic                take_eq;
    logic                take_neg;
    logic signed [W-1:0] d_s;
    logic signed [W-1:0] a_next;
    logic signed [W-1:0] b_next;
    logic                a_fits;
    logic                b_fits;
    logic                res_fits;

    function automatic logic in_range(input logic signed [W-1:0] v);
        return (v <= MAX_S) && (v >= MIN_S);
    endfunction

    // A raw strobe blocks every lower-priority strobe even when its payload is invalid.
    always_comb begin
        take_digit = digit_vld && (digit <= 4'd9);
        take_op    = !digit_vld && op_vld &&
                     (op_code == 3'b010 || op_code == 3'b011 ||
                      op_code == 3'b100 || op_code == 3'b101);
        take_eq    = !digit_vld && !op_vld && eq_vld;
        take_neg   = !digit_vld && !op_vld && !eq_vld && neg_vld;
    end

    // Next operand value: cur*10 + sign(cur)*digit, with B's sign armed while B is still zero.
    always_comb begin
        d_s      = {{(W-4){1'b0}}, digit};
        a_next   = (a <<< 3) + (a <<< 1) + (a[W-1] ? -d_s : d_s);
        b_next   = (b <<< 3) + (b <<< 1) +
                   ((b[W-1] || (b == '0 && b_neg)) ? -d_s : d_s);
        a_fits   = in_range(a_next);
        b_fits   = in_range(b_next);
        res_fits = in_range(alu_result);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= S_ENTER_A;
            a          <= '0;
            b          <= '0;
            b_neg      <= 1'b0;
            op         <= 3'b000;
            pend_op    <= 3'b000;
            chain_pend <= 1'b0;
            alu_start  <= 1'b0;
            alu_op     <= 3'b000;
            alu_a      <= '0;
            alu_b      <= '0;
            disp_val   <= '0;
            disp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                S_ENTER_A: begin
                    if (take_digit) begin
                        if (a_fits) begin
                            a        <= a_next;
                            disp_val <= a_next;
                        end
                    end else if (take_op) begin
                        op    <= op_code;
                        b     <= '0;
                        b_neg <= 1'b0;
                        state <= S_OP_WAIT;
                    end else if (take_neg) begin
                        a        <= -a;
                        disp_val <= -a;
                    end
                end

                S_OP_WAIT: begin
                    if (take_digit) begin
                        b        <= b_next;
                        disp_val <= b_next;
                        state    <= S_ENTER_B;
                    end else if (take_op) begin
                        op <= op_code;
                    end else if (take_eq) begin
                        b         <= a;
                        alu_start <= 1'b1;
                        alu_op    <= op;
                        alu_a     <= a;
                        alu_b     <= a;
                        busy      <= 1'b1;
                        state     <= S_EXEC;
                    end else if (take_neg) begin
                        b_neg <= ~b_neg;
                    end
                end

                S_ENTER_B: begin
                    if (take_digit) begin
                        if (b_fits) begin
                            b        <= b_next;
                            disp_val <= b_next;
                        end
                    end else if (take_op) begin
`ifdef CALC_CHAIN_EN
                        alu_start  <= 1'b1;
                        alu_op     <= op;
                        alu_a      <= a;
                        alu_b      <= b;
                        busy       <= 1'b1;
                        pend_op    <= op_code;
                        chain_pend <= 1'b1;
                        state      <= S_EXEC;
`else
                        // Without chaining the operator press has no effect here.
                        state <= S_ENTER_B;
`endif
                    end else if (take_eq) begin
                        alu_start <= 1'b1;
                        alu_op    <= op;
                        alu_a     <= a;
                        alu_b     <= b;
                        busy      <= 1'b1;
                        state     <= S_EXEC;
                    end else if (take_neg) begin
                        b        <= -b;
                        b_neg    <= ~b_neg;
                        disp_val <= -b;
                    end
                end

                S_EXEC: begin
                    if (alu_done) begin
                        busy       <= 1'b0;
                        chain_pend <= 1'b0;
                        if (alu_err || !res_fits) begin
                            disp_err <= 1'b1;
                            disp_val <= '0;
                            state    <= S_ERROR;
                        end else begin
                            a        <= alu_result;
                            disp_val <= alu_result;
                            if (chain_pend) begin
                                op    <= pend_op;
                                b     <= '0;
                                b_neg <= 1'b0;
                                state <= S_OP_WAIT;
                            end else begin
                                state <= S_RESULT;
                            end
                        end
                    end
                end

                S_RESULT: begin
                    if (take_digit) begin
                        a        <= d_s;
                        disp_val <= d_s;
                        state    <= S_ENTER_A;
                    end else if (take_op) begin
                        op    <= op_code;
                        b     <= '0;
                        b_neg <= 1'b0;
                        state <= S_OP_WAIT;
                    end else if (take_eq) begin
                        // Repeat: same operator and B, with the previous result as A.
                        alu_start <= 1'b1;
                        alu_op    <= op;
                        alu_a     <= a;
                        alu_b     <= b;
                        busy      <= 1'b1;
                        state     <= S_EXEC;
                    end else if (take_neg) begin
                        a        <= -a;
                        disp_val <= -a;
                    end
                end

                S_ERROR: begin
                    if (take_digit) begin
                        disp_err <= 1'b0;
                        a        <= d_s;
                        disp_val <= d_s;
                        state    <= S_ENTER_A;
                    end
                end

                default: state <= S_ENTER_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: button sequences with a responding ALU and hand-computed expectations.
module tb_calc_seq_ctrl;
    localparam int W = 16;
    localparam logic [2:0] ST_ENTER_A = 3'd0, ST_OP_WAIT = 3'd1, ST_ENTER_B = 3'd2,
                           ST_EXEC = 3'd3, ST_RESULT = 3'd4, ST_ERROR = 3'd5;

    logic                clk = 1'b0;
    logic                clr_n = 1'b0;
    logic                digit_vld = 1'b0;
    logic [3:0]          digit = 4'd0;
    logic                op_vld = 1'b0;
    logic [2:0]          op_code = 3'd0;
    logic                eq_vld = 1'b0;
    logic                neg_vld = 1'b0;
    logic                alu_start;
    logic [2:0]          alu_op;
    logic signed [W-1:0] alu_a;
    logic signed [W-1:0] alu_b;
    logic                alu_done = 1'b0;
    logic signed [W-1:0] alu_result = '0;
    logic                alu_err = 1'b0;
    logic signed [W-1:0] disp_val;
    logic                disp_err;
    logic                busy;
    logic [2:0]          state_dbg;

    int errors = 0;
    int checks = 0;

    calc_seq_ctrl #(.W(W), .MAX_VAL(999)) dut (
        .clk(clk), .clr_n(clr_n), .digit_vld(digit_vld), .digit(digit),
        .op_vld(op_vld), .op_code(op_code), .eq_vld(eq_vld), .neg_vld(neg_vld),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .disp_val(disp_val), .disp_err(disp_err), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle strobe set driven between negedges; results are visible at the following negedge.
    task automatic strobe(input logic dv, input logic [3:0] d, input logic ov,
                          input logic [2:0] oc, input logic ev, input logic nv);
        @(negedge clk);
        digit_vld = dv; digit = d; op_vld = ov; op_code = oc; eq_vld = ev; neg_vld = nv;
        @(negedge clk);
        digit_vld = 1'b0; digit = 4'd0; op_vld = 1'b0; op_code = 3'd0; eq_vld = 1'b0; neg_vld = 1'b0;
    endtask

    task automatic press_digit(input logic [3:0] d); strobe(1'b1, d, 1'b0, 3'd0, 1'b0, 1'b0); endtask
    task automatic press_op(input logic [2:0] c);   strobe(1'b0, 4'd0, 1'b1, c, 1'b0, 1'b0); endtask
    task automatic press_eq();                      strobe(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0); endtask
    task automatic press_neg();                     strobe(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1); endtask

    task automatic do_clear();
        @(negedge clk); clr_n = 1'b0;
        @(negedge clk); clr_n = 1'b1;
    endtask

    // ALU responder: waits (bounded) for alu_start, checks operands, answers two cycles later.
    task automatic alu_serve(input string name, input logic signed [W-1:0] ea, input logic signed [W-1:0] eb,
                             input logic [2:0] eop, input logic signed [W-1:0] res, input logic er);
        int n = 0;
        while (alu_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (alu_start !== 1'b1) begin errors++; $display("FAIL %s_start: alu_start=%b want 1 within 20 cycles", name, alu_start); end
        checks++;
        if (alu_a !== ea || alu_b !== eb || alu_op !== eop) begin
            errors++;
            $display("FAIL %s_operands: got a=%0d b=%0d op=%b want a=%0d b=%0d op=%b", name, alu_a, alu_b, alu_op, ea, eb, eop);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: busy=%b want 1", name, busy); end
        @(negedge clk);
        checks++;
        if (alu_start !== 1'b0 || alu_a !== ea || alu_b !== eb) begin
            errors++; $display("FAIL %s_hold: alu_start=%b a=%0d b=%0d want 0,%0d,%0d", name, alu_start, alu_a, alu_b, ea, eb);
        end
        @(negedge clk);
        alu_done = 1'b1; alu_result = res; alu_err = er;
        @(negedge clk);
        alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (alu_start !== 1'b0 || alu_op !== 3'd0 || alu_a !== 16'sd0 || alu_b !== 16'sd0) begin
            errors++; $display("FAIL reset_alu: start=%b op=%b a=%0d b=%0d want all 0", alu_start, alu_op, alu_a, alu_b);
        end
        checks++;
        if (disp_val !== 16'sd0 || disp_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_disp: val=%0d err=%b busy=%b want 0,0,0", disp_val, disp_err, busy);
        end
        checks++;
        if (state_dbg !== ST_ENTER_A) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_ENTER_A); end
        clr_n = 1'b1;
    endtask

    task automatic test_add();
        press_digit(4'd1);
        press_digit(4'd2);
        checks++;
        if (disp_val !== 16'sd12) begin errors++; $display("FAIL add_entry_a: got %0d want 12", disp_val); end
        press_op(3'b010);
        checks++;
        if (state_dbg !== ST_OP_WAIT || disp_val !== 16'sd12) begin
            errors++; $display("FAIL add_op_wait: state=%0d disp=%0d want %0d,12", state_dbg, disp_val, ST_OP_WAIT);
        end
        press_digit(4'd3);
        press_digit(4'd4);
        checks++;
        if (disp_val !== 16'sd34 || state_dbg !== ST_ENTER_B) begin
            errors++; $display("FAIL add_entry_b: disp=%0d state=%0d want 34,%0d", disp_val, state_dbg, ST_ENTER_B);
        end
        press_eq();
        checks++;
        if (alu_start !== 1'b1) begin errors++; $display("FAIL add_latency: alu_start=%b want 1 one cycle after eq", alu_start); end
        alu_serve("add", 16'sd12, 16'sd34, 3'b010, 16'sd46, 1'b0);
        checks++;
        if (disp_val !== 16'sd46 || disp_err !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_RESULT) begin
            errors++; $display("FAIL add_result: disp=%0d err=%b busy=%b state=%0d want 46,0,0,%0d", disp_val, disp_err, busy, state_dbg, ST_RESULT);
        end
    endtask

    task automatic test_back_to_back();
        press_eq();
        alu_serve("repeat", 16'sd46, 16'sd34, 3'b010, 16'sd80, 1'b0);
        checks++;
        if (disp_val !== 16'sd80) begin errors++; $display("FAIL repeat_result: got %0d want 80", disp_val); end
        press_neg();
        checks++;
        if (disp_val !== -16'sd80) begin errors++; $display("FAIL result_neg: got %0d want -80", disp_val); end
        press_op(3'b011);
        press_neg();
        press_digit(4'd2);
        checks++;
        if (disp_val !== -16'sd2) begin errors++; $display("FAIL armed_b: got %0d want -2", disp_val); end
        press_eq();
        alu_serve("sub", -16'sd80, -16'sd2, 3'b011, -16'sd78, 1'b0);
        checks++;
        if (disp_val !== -16'sd78) begin errors++; $display("FAIL sub_result: got %0d want -78", disp_val); end
    endtask

    task automatic test_neg_mul();
        do_clear();
        press_digit(4'd7);
        press_neg();
        checks++;
        if (disp_val !== -16'sd7) begin errors++; $display("FAIL neg_a: got %0d want -7", disp_val); end
        press_op(3'b101);
        press_digit(4'd3);
        press_eq();
        alu_serve("mul", -16'sd7, 16'sd3, 3'b101, -16'sd21, 1'b0);
        checks++;
        if (disp_val !== -16'sd21 || disp_err !== 1'b0) begin
            errors++; $display("FAIL mul_result: disp=%0d err=%b want -21,0", disp_val, disp_err);
        end
        press_eq();
        alu_serve("range", -16'sd21, 16'sd3, 3'b101, -16'sd1000, 1'b0);
        checks++;
        if (disp_err !== 1'b1 || disp_val !== 16'sd0 || state_dbg !== ST_ERROR) begin
            errors++; $display("FAIL range_err: err=%b disp=%0d state=%0d want 1,0,%0d", disp_err, disp_val, state_dbg, ST_ERROR);
        end
    endtask

    task automatic test_div_err();
        do_clear();
        press_digit(4'd9);
        press_op(3'b100);
        press_digit(4'd0);
        press_eq();
        alu_serve("div0", 16'sd9, 16'sd0, 3'b100, 16'sd0, 1'b1);
        checks++;
        if (disp_err !== 1'b1 || disp_val !== 16'sd0 || state_dbg !== ST_ERROR) begin
            errors++; $display("FAIL div0_err: err=%b disp=%0d state=%0d want 1,0,%0d", disp_err, disp_val, state_dbg, ST_ERROR);
        end
        press_eq();
        press_op(3'b010);
        checks++;
        if (state_dbg !== ST_ERROR || disp_err !== 1'b1) begin
            errors++; $display("FAIL err_hold: state=%0d err=%b want %0d,1", state_dbg, disp_err, ST_ERROR);
        end
        press_digit(4'd5);
        checks++;
        if (disp_err !== 1'b0 || disp_val !== 16'sd5 || state_dbg !== ST_ENTER_A) begin
            errors++; $display("FAIL err_exit: err=%b disp=%0d state=%0d want 0,5,%0d", disp_err, disp_val, state_dbg, ST_ENTER_A);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        press_digit(4'd9);
        press_digit(4'd9);
        press_digit(4'd9);
        press_digit(4'd9);
        checks++;
        if (disp_val !== 16'sd999 || state_dbg !== ST_ENTER_A) begin
            errors++; $display("FAIL sat_pos: disp=%0d state=%0d want 999,%0d", disp_val, state_dbg, ST_ENTER_A);
        end
        press_neg();
        press_digit(4'd9);
        checks++;
        if (disp_val !== -16'sd999) begin errors++; $display("FAIL sat_neg: got %0d want -999", disp_val); end
        do_clear();
        strobe(1'b1, 4'd3, 1'b1, 3'b010, 1'b0, 1'b0);
        checks++;
        if (disp_val !== 16'sd3 || state_dbg !== ST_ENTER_A) begin
            errors++; $display("FAIL prio_digit_op: disp=%0d state=%0d want 3,%0d", disp_val, state_dbg, ST_ENTER_A);
        end
        strobe(1'b1, 4'd4, 1'b0, 3'd0, 1'b1, 1'b1);
        checks++;
        if (disp_val !== 16'sd34 || state_dbg !== ST_ENTER_A) begin
            errors++; $display("FAIL prio_digit_eq_neg: disp=%0d state=%0d want 34,%0d", disp_val, state_dbg, ST_ENTER_A);
        end
    endtask

    task automatic test_clear_busy();
        do_clear();
        press_digit(4'd5);
        press_op(3'b010);
        press_digit(4'd5);
        press_eq();
        checks++;
        if (busy !== 1'b1 || state_dbg !== ST_EXEC) begin errors++; $display("FAIL clr_busy_pre: busy=%b state=%0d want 1,%0d", busy, state_dbg, ST_EXEC); end
        @(negedge clk); clr_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || alu_start !== 1'b0 || alu_a !== 16'sd0 || alu_b !== 16'sd0 || alu_op !== 3'd0 || disp_val !== 16'sd0) begin
            errors++; $display("FAIL clr_async: busy=%b start=%b a=%0d b=%0d op=%b disp=%0d want all 0", busy, alu_start, alu_a, alu_b, alu_op, disp_val);
        end
        @(negedge clk); clr_n = 1'b1;
        @(negedge clk); alu_done = 1'b1; alu_result = 16'sd10;
        @(negedge clk); alu_done = 1'b0; alu_result = '0;
        checks++;
        if (disp_val !== 16'sd0 || disp_err !== 1'b0 || busy !== 1'b0 || state_dbg !== ST_ENTER_A) begin
            errors++; $display("FAIL clr_late_done: disp=%0d err=%b busy=%b state=%0d want 0,0,0,%0d", disp_val, disp_err, busy, state_dbg, ST_ENTER_A);
        end
    endtask

    task automatic test_chain();
        do_clear();
        press_digit(4'd2);
        press_op(3'b010);
        press_digit(4'd3);
        press_op(3'b010);
`ifdef CALC_CHAIN_EN
        alu_serve("chain1", 16'sd2, 16'sd3, 3'b010, 16'sd5, 1'b0);
        checks++;
        if (state_dbg !== ST_OP_WAIT || disp_val !== 16'sd5) begin
            errors++; $display("FAIL chain_mid: state=%0d disp=%0d want %0d,5", state_dbg, disp_val, ST_OP_WAIT);
        end
        press_digit(4'd4);
        press_eq();
        alu_serve("chain2", 16'sd5, 16'sd4, 3'b010, 16'sd9, 1'b0);
        checks++;
        if (disp_val !== 16'sd9) begin errors++; $display("FAIL chain_result: got %0d want 9", disp_val); end
`else
        checks++;
        if (state_dbg !== ST_ENTER_B || busy !== 1'b0) begin
            errors++; $display("FAIL nochain_op: state=%0d busy=%b want %0d,0", state_dbg, busy, ST_ENTER_B);
        end
        press_digit(4'd4);
        press_eq();
        alu_serve("nochain", 16'sd2, 16'sd34, 3'b010, 16'sd36, 1'b0);
        checks++;
        if (disp_val !== 16'sd36) begin errors++; $display("FAIL nochain_result: got %0d want 36", disp_val); end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_neg_mul();
        test_div_err();
        test_saturate();
        test_clear_busy();
        test_chain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
